// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Runs one DSP48A1 slice (A1REG=B1REG=MREG=PREG=OPMODEREG=1, CEA/CEB/CEM/
//   CEOPMODE tied high, slice resets tied low) as a signed dot-product engine.
//   Operand pairs stream in over IN_VALID/IN_READY; a 3-stage slot shift
//   register places OPMODE one cycle after each accept and CEP two cycles
//   after it, so the slice pipeline is stepped exactly once per pair.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   START, START_READY    vector start handshake (START_READY high in IDLE)
//   LEN                   vector length, sampled when START is accepted
//   ABORT                 cancels a vector in RUN, DRAIN or DONE
//   IN_VALID, IN_READY    operand pair handshake
//   IN_A, IN_B            signed operands
//   RES_VALID, RES_READY  result handshake
//   RES_DATA              accumulated dot product (held while RES_VALID)
//   BUSY                  high whenever the sequencer is not idle
//   DSP_A, DSP_B          operands straight to slice A/B
//   DSP_OPMODE, DSP_CEP   slice control
//   DSP_P                 slice accumulator output
module dsp_mac_sequencer #(
   parameter int unsigned LW      = 16,
   parameter int unsigned WIDTH_2 = 18,
   parameter int unsigned WIDTH_4 = 48
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   output logic               START_READY,
   input  logic [LW-1:0]      LEN,
   input  logic               ABORT,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [WIDTH_2-1:0] IN_A,
   input  logic [WIDTH_2-1:0] IN_B,
   output logic               RES_VALID,
   input  logic               RES_READY,
   output logic [WIDTH_4-1:0] RES_DATA,
   output logic               BUSY,
   output logic [WIDTH_2-1:0] DSP_A,
   output logic [WIDTH_2-1:0] DSP_B,
   output logic [7:0]         DSP_OPMODE,
   output logic               DSP_CEP,
   input  logic [WIDTH_4-1:0] DSP_P
);

   localparam int unsigned NSTG = 3;

   // X=M, Z=0 starts a new sum; X=M, Z=P accumulates; all-zero is a bubble
   localparam logic [7:0] OPM_BUBBLE = 8'h00;
   localparam logic [7:0] OPM_FIRST  = 8'h01;
   localparam logic [7:0] OPM_ACC    = 8'h09;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   logic              zero_q, zero_d;
   logic              first_pend_q, first_pend_d;
   logic [NSTG-1:0]   vld_q, vld_d;
   logic              first1_q, first1_d;
   logic              accept;

   // Operands go straight to the slice; its A1/B1 registers do the capture
   assign DSP_A = IN_A;
   assign DSP_B = IN_B;

   // A pair offered alongside ABORT is refused
   assign IN_READY = (state_q == S_RUN) && !ABORT;
   assign accept   = IN_VALID && IN_READY;

   assign START_READY = (state_q == S_IDLE);
   assign RES_VALID   = (state_q == S_DONE);

   // Stage 3 only holds a slot outside IDLE; folding it in keeps BUSY true
   // for as long as any slot is still in flight
   assign BUSY = (state_q != S_IDLE) || vld_q[NSTG-1];

   // Stage 1 selects OPMODE (registered by the slice), stage 2 enables P
   assign DSP_OPMODE = vld_q[0] ? (first1_q ? OPM_FIRST : OPM_ACC) : OPM_BUBBLE;
   assign DSP_CEP    = vld_q[1];

   // P is untouched in DONE (no slot left to raise CEP), so this is stable
   assign RES_DATA = ((state_q == S_DONE) && !zero_q) ? DSP_P : '0;

   // Next-state, counter, flag and slot shift logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      zero_d       = zero_q;
      first_pend_d = first_pend_q;
      vld_d        = {vld_q[NSTG-2:0], 1'b0};
      first1_d     = 1'b0;

      if (accept) begin
         vld_d[0]     = 1'b1;
         first1_d     = first_pend_q;
         first_pend_d = 1'b0;
         cnt_d        = cnt_q - LW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (START) begin
               if (LEN == '0) begin
                  zero_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cnt_d        = LEN;
                  first_pend_d = 1'b1;
                  state_d      = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (accept && (cnt_q == LW'(1))) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Last slot is in stage 2 with nothing behind it: P lands this edge
            if (!vld_q[0]) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (RES_READY) begin
               zero_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything, including RES_READY
      if (ABORT && (state_q != S_IDLE)) begin
         state_d      = S_IDLE;
         cnt_d        = '0;
         zero_d       = 1'b0;
         first_pend_d = 1'b0;
         vld_d        = '0;
         first1_d     = 1'b0;
      end
   end

   // State and control registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         zero_q       <= 1'b0;
         first_pend_q <= 1'b0;
         vld_q        <= '0;
         first1_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         zero_q       <= zero_d;
         first_pend_q <= first_pend_d;
         vld_q        <= vld_d;
         first1_q     <= first1_d;
      end
   end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model
// (A1/B1, M, OPMODE and P registers; M zero-extended into X).
module tb_dsp_mac_sequencer;

   localparam int unsigned LW = 16;
   localparam int unsigned W2 = 18;
   localparam int unsigned W4 = 48;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          START = 1'b0;
   logic          START_READY;
   logic [LW-1:0] LEN = '0;
   logic          ABORT = 1'b0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY;
   logic [W2-1:0] IN_A = '0;
   logic [W2-1:0] IN_B = '0;
   logic          RES_VALID;
   logic          RES_READY = 1'b0;
   logic [W4-1:0] RES_DATA;
   logic          BUSY;
   logic [W2-1:0] DSP_A;
   logic [W2-1:0] DSP_B;
   logic [7:0]    DSP_OPMODE;
   logic          DSP_CEP;
   logic [W4-1:0] DSP_P;

   dsp_mac_sequencer #(.LW(LW), .WIDTH_2(W2), .WIDTH_4(W4)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .START_READY(START_READY),
      .LEN(LEN), .ABORT(ABORT), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_A(IN_A), .IN_B(IN_B), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_DATA(RES_DATA), .BUSY(BUSY), .DSP_A(DSP_A), .DSP_B(DSP_B),
      .DSP_OPMODE(DSP_OPMODE), .DSP_CEP(DSP_CEP), .DSP_P(DSP_P)
   );

   always #5 CLK = ~CLK;

   // Slice model: never reset, as in the real system
   logic signed [W2-1:0] a1, b1;
   logic signed [35:0]   m_r;
   logic [7:0]           opm_r;
   logic [W4-1:0]        p_r;
   logic [W4-1:0]        x_mux, z_mux;
   assign x_mux = (opm_r[1:0] == 2'b01) ? {12'd0, m_r} : '0;
   assign z_mux = (opm_r[3:2] == 2'b10) ? p_r : '0;
   always @(posedge CLK) begin
      a1    <= DSP_A;
      b1    <= DSP_B;
      m_r   <= a1 * b1;
      opm_r <= DSP_OPMODE;
      if (DSP_CEP) p_r <= z_mux + x_mux;
   end
   assign DSP_P = p_r;

   int checks = 0;
   int failures = 0;
   int cep_cnt = 0;
   logic [W4-1:0] exp_q[$];

   always @(negedge CLK) if (DSP_CEP === 1'b1) cep_cnt++;

   typedef struct packed {
      logic [15:0]       len;
      logic [3:0][17:0]  a;
      logic [3:0][17:0]  b;
      logic [7:0]        gap_at;
      logic [7:0]        gap_len;
      logic [7:0]        hold;
      logic [47:0]       exp;
   } vec_t;

   vec_t vecs [6];

   function automatic vec_t mk(input int len,
                               input logic [17:0] a0, a1_, a2, a3,
                               input logic [17:0] b0, b1_, b2, b3,
                               input int gap_at, input int gap_len,
                               input int hold, input logic [47:0] exp);
      vec_t v;
      v.len = 16'(len);
      v.a[0] = a0; v.a[1] = a1_; v.a[2] = a2; v.a[3] = a3;
      v.b[0] = b0; v.b[1] = b1_; v.b[2] = b2; v.b[3] = b3;
      v.gap_at = 8'(gap_at);
      v.gap_len = 8'(gap_len);
      v.hold = 8'(hold);
      v.exp = exp;
      return v;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start_ready"}, 64'(START_READY), 64'd1);
      check({tag, "_in_ready"},    64'(IN_READY),    64'd0);
      check({tag, "_res_valid"},   64'(RES_VALID),   64'd0);
      check({tag, "_busy"},        64'(BUSY),        64'd0);
      check({tag, "_cep"},         64'(DSP_CEP),     64'd0);
      check({tag, "_opmode"},      64'(DSP_OPMODE),  64'd0);
      check({tag, "_res_data"},    64'(RES_DATA),    64'd0);
   endtask

   task automatic wait_start_ready();
      int n = 0;
      while (START_READY !== 1'b1 && n < 50) begin step(); n++; end
      if (n >= 50) begin
         checks++; failures++;
         $display("FAIL start_ready_timeout actual=0 required=1");
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      int cep0;
      int n;
      logic stable;
      logic [W4-1:0] held;
      logic [W4-1:0] expv;
      wait_start_ready();
      cep0 = cep_cnt;
      START = 1'b1; LEN = v.len;
      exp_q.push_back(v.exp);
      step();
      START = 1'b0; LEN = '0;
      for (int k = 0; k < int'(v.len); k++) begin
         if (k == int'(v.gap_at)) begin
            IN_VALID = 1'b0;
            repeat (int'(v.gap_len)) step();
         end
         IN_VALID = 1'b1; IN_A = v.a[k]; IN_B = v.b[k];
         n = 0;
         while (IN_READY !== 1'b1 && n < 20) begin step(); n++; end
         if (n >= 20) begin
            checks++; failures++;
            $display("FAIL %s_in_ready_timeout actual=0 required=1", tag);
         end
         step();
      end
      IN_VALID = 1'b0;
      lat = 1;
      while (RES_VALID !== 1'b1 && lat < 20) begin step(); lat++; end
      check({tag, "_latency"}, 64'(lat), (v.len == 0) ? 64'd1 : 64'd3);
      if (v.hold != 0) begin
         held = RES_DATA; stable = 1'b1;
         START = 1'b1; LEN = 16'd5;
         repeat (int'(v.hold)) begin
            step();
            if (RES_DATA !== held || START_READY !== 1'b0 || RES_VALID !== 1'b1) stable = 1'b0;
         end
         START = 1'b0; LEN = '0;
         check({tag, "_hold_stable"}, 64'(stable), 64'd1);
      end
      RES_READY = 1'b1;
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check({tag, "_res_data"}, 64'(RES_DATA), 64'(expv));
      step();
      RES_READY = 1'b0;
      check({tag, "_start_ready_after"}, 64'(START_READY), 64'd1);
      check({tag, "_res_valid_after"}, 64'(RES_VALID), 64'd0);
      step();
      check({tag, "_cep_count"}, 64'(cep_cnt - cep0), 64'(v.len));
   endtask

   initial begin
      int cep0;
      logic rv;
      // len, a0..a3, b0..b3, gap_at, gap_len, hold, expected
      vecs[0] = mk(3, 18'd2, 18'd4, 18'd7, 18'd0, 18'd3, 18'd5, 18'd1, 18'd0, 255, 0, 0, 48'd33);
      vecs[1] = mk(4, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 2, 2, 0, 48'd4);
      vecs[2] = mk(1, 18'd100, 18'd0, 18'd0, 18'd0, 18'h3FFFF, 18'd0, 18'd0, 18'd0, 255, 0, 0, 48'h000F_FFFF_FF9C);
      vecs[3] = mk(1, 18'd5, 18'd0, 18'd0, 18'd0, 18'd5, 18'd0, 18'd0, 18'd0, 255, 0, 10, 48'd25);
      vecs[4] = mk(0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 255, 0, 0, 48'd0);
      vecs[5] = mk(2, 18'd3, 18'd3, 18'd0, 18'd0, 18'd3, 18'd3, 18'd0, 18'd0, 255, 0, 0, 48'd18);

      step(); step();
      check_reset_outputs("in_reset");
      RST_N = 1'b1;
      step();
      check_reset_outputs("post_reset");

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Abort after 2 of 5 pairs
      wait_start_ready();
      START = 1'b1; LEN = 16'd5;
      step();
      START = 1'b0; LEN = '0;
      IN_VALID = 1'b1; IN_A = 18'd1; IN_B = 18'd1;
      step(); step();
      ABORT = 1'b1; IN_A = 18'd9;
      step();
      ABORT = 1'b0; IN_VALID = 1'b0;
      check("abort_start_ready", 64'(START_READY), 64'd1);
      check("abort_busy", 64'(BUSY), 64'd0);
      cep0 = cep_cnt; rv = 1'b0;
      repeat (6) begin step(); if (RES_VALID === 1'b1) rv = 1'b1; end
      check("abort_no_cep", 64'(cep_cnt - cep0), 64'd0);
      check("abort_no_res_valid", 64'(rv), 64'd0);
      run_vec(vecs[5], "after_abort");

      // Reset pulsed mid-RUN
      wait_start_ready();
      START = 1'b1; LEN = 16'd3;
      step();
      START = 1'b0; LEN = '0;
      IN_VALID = 1'b1; IN_A = 18'd2; IN_B = 18'd2;
      step(); step();
      RST_N = 1'b0;
      #1;
      check_reset_outputs("mid_run_reset");
      IN_VALID = 1'b0;
      step();
      RST_N = 1'b1;
      step();
      run_vec(vecs[3], "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
